// File: rtl/board_lock_commit_pkg.sv
// Shared constants, types and state encoding for the board lock/commit block.
package board_lock_commit_pkg;

    localparam int unsigned ROWS      = 12;
    localparam int unsigned CELL_W    = 3;
    localparam int unsigned SCORE_W   = 16;
    localparam int unsigned NUM_COLS  = 8;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned COL_W     = ROWS * CELL_W;
    localparam int unsigned MASK_BITS = 4;

    typedef logic [COL_W-1:0] column_t;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StScan,
        StCheck,
        StWait,
        StOver
    } state_e;

    // Mask bit b covers cell (x + b[0], y + b[1]).
    function automatic int mask_dx(int bit_idx);
        return bit_idx % 2;
    endfunction

    function automatic int mask_dy(int bit_idx);
        return bit_idx / 2;
    endfunction

endpackage

// File: rtl/board_lock_commit_if.sv
// Lock request / result handshake with the piece controller plus the check strobe
// exchanged with the end-game checker.
interface board_lock_commit_if;
    import board_lock_commit_pkg::*;

    logic              lock_req;
    logic [2:0]        piece_x;
    logic [3:0]        piece_y;
    logic [3:0]        piece_mask;
    logic [CELL_W-1:0] piece_colour;
    logic              ready;
    logic              lock_done;
    logic [1:0]        lines_cleared;
    logic              touch_top;
    logic              end_game;
    logic              checked_game;

    modport master (
        output lock_req, piece_x, piece_y, piece_mask, piece_colour, end_game, checked_game,
        input  ready, lock_done, lines_cleared, touch_top
    );

    modport slave (
        input  lock_req, piece_x, piece_y, piece_mask, piece_colour, end_game, checked_game,
        output ready, lock_done, lines_cleared, touch_top
    );

endinterface

// File: rtl/board_row_shift.sv
// Removes row `row` from one column: rows above move down one, zero enters at the top.
module board_row_shift
    import board_lock_commit_pkg::*;
(
    input  column_t          col,
    input  logic [ROW_W-1:0] row,
    output column_t          shifted
);

    always_comb begin
        shifted = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (i < int'(row)) begin
                shifted[i*CELL_W +: CELL_W] = col[i*CELL_W +: CELL_W];
            end else if (i < int'(ROWS) - 1) begin
                shifted[i*CELL_W +: CELL_W] = col[(i+1)*CELL_W +: CELL_W];
            end
        end
    end

endmodule

// File: rtl/board_lock_commit.sv
// Commits a landed 2x2 piece into the playfield, clears full rows, then runs the
// end-of-game check handshake before accepting the next piece.
module board_lock_commit
    import board_lock_commit_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    board_lock_commit_if.slave bus,
    output logic [COL_W-1:0]   c1,
    output logic [COL_W-1:0]   c2,
    output logic [COL_W-1:0]   c3,
    output logic [COL_W-1:0]   c4,
    output logic [COL_W-1:0]   c5,
    output logic [COL_W-1:0]   c6,
    output logic [COL_W-1:0]   c7,
    output logic [COL_W-1:0]   c8,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    state_e             state_q, state_d;
    column_t            cols_q [NUM_COLS];
    column_t            cols_d [NUM_COLS];
    column_t            shifted [NUM_COLS];
    logic [2:0]         px_q, px_d;
    logic [3:0]         py_q, py_d;
    logic [3:0]         mask_q, mask_d;
    logic [CELL_W-1:0]  colour_q, colour_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         clr_q, clr_d;
    logic [1:0]         lines_q, lines_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               done_q, done_d;
    logic               row_full;
    logic [3:0]         cx;
    logic [4:0]         cy;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_shift
        board_row_shift u_shift (
            .col     (cols_q[c]),
            .row     (row_q),
            .shifted (shifted[c])
        );
    end

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < int'(NUM_COLS); c++) begin
            if (cols_q[c][32'(row_q)*CELL_W +: CELL_W] == '0) row_full = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cols_d   = cols_q;
        px_d     = px_q;
        py_d     = py_q;
        mask_d   = mask_q;
        colour_d = colour_q;
        row_d    = row_q;
        clr_d    = clr_q;
        lines_d  = lines_q;
        score_d  = score_q;
        done_d   = 1'b0;
        cx       = '0;
        cy       = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.lock_req) begin
                    px_d     = bus.piece_x;
                    py_d     = bus.piece_y;
                    mask_d   = bus.piece_mask;
                    colour_d = bus.piece_colour;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                // Off-board cells (column 8 or row >= ROWS) are silently dropped.
                for (int b = 0; b < int'(MASK_BITS); b++) begin
                    cx = {1'b0, px_q} + 4'(mask_dx(b));
                    cy = {1'b0, py_q} + 5'(mask_dy(b));
                    if (mask_q[b] && !cx[3] && (cy < 5'(ROWS))) begin
                        cols_d[cx[2:0]][32'(cy)*CELL_W +: CELL_W] = colour_q;
                    end
                end
                row_d   = '0;
                clr_d   = '0;
                state_d = StScan;
            end
            StScan: begin
                if (row_full) begin
                    cols_d = shifted;
                    if (clr_q != 2'd3) clr_d = clr_q + 2'd1;
                end else if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = StCheck;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StCheck: state_d = StWait;
            StWait: begin
                if (bus.end_game) begin
                    state_d = StOver;
                end else if (bus.checked_game) begin
                    done_d  = 1'b1;
                    lines_d = clr_q;
                    score_d = score_q + SCORE_W'(clr_q);
                    state_d = StIdle;
                end else begin
                    state_d = StCheck;
                end
            end
            StOver:  state_d = StOver;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            for (int c = 0; c < int'(NUM_COLS); c++) cols_q[c] <= '0;
            px_q     <= '0;
            py_q     <= '0;
            mask_q   <= '0;
            colour_q <= '0;
            row_q    <= '0;
            clr_q    <= '0;
            lines_q  <= '0;
            score_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cols_q   <= cols_d;
            px_q     <= px_d;
            py_q     <= py_d;
            mask_q   <= mask_d;
            colour_q <= colour_d;
            row_q    <= row_d;
            clr_q    <= clr_d;
            lines_q  <= lines_d;
            score_q  <= score_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready         = (state_q == StIdle);
    assign bus.touch_top     = (state_q == StCheck);
    assign bus.lock_done     = done_q;
    assign bus.lines_cleared = lines_q;
    assign score             = score_q;
    assign game_over         = (state_q == StOver);

    assign c1 = cols_q[0];
    assign c2 = cols_q[1];
    assign c3 = cols_q[2];
    assign c4 = cols_q[3];
    assign c5 = cols_q[4];
    assign c6 = cols_q[5];
    assign c7 = cols_q[6];
    assign c8 = cols_q[7];

endmodule

// File: doc/board_lock_commit.md
Name: board_lock_commit

Overview:
- Initiator side of the end-of-game check handshake.
- Owns the 8-column playfield registers. On a lock request it writes the landed piece into the board, clears full rows, then drives touch_top. It samples the checker's end_game/checked_game to decide between "ready for next piece" and "game over".
- Sits between the falling-piece controller (upstream) and the end-game checker and VGA renderer (downstream, both read c1..c8).

Parameters:
- ROWS, 12, rows per column; row 0 = bottom, row ROWS-1 = top.
- CELL_W, 3, colour bits per cell; 0 = empty.
- SCORE_W, 16, width of the cleared-line total.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- lock_req  in  1  one-cycle request to commit a piece; accepted only when ready=1
- piece_x  in  3  anchor column 0..7 (column c(k+1) holds x=k)
- piece_y  in  4  anchor row, bottom-left of piece
- piece_mask  in  4  2x2 occupancy: bit0 (x,y), bit1 (x+1,y), bit2 (x,y+1), bit3 (x+1,y+1)
- piece_colour  in  CELL_W  colour written to occupied cells
- end_game  in  1  checker result: top row occupied
- checked_game  in  1  checker result: top row clear
- touch_top  out  1  check strobe to checker
- c1..c8  out  ROWS*CELL_W each  column contents; row r at bits [CELL_W*r+CELL_W-1 : CELL_W*r]
- ready  out  1  idle and accepting lock_req
- lock_done  out  1  one-cycle pulse when a commit finishes without game over
- lines_cleared  out  2  rows cleared by the last commit (0..2); valid with lock_done
- score  out  SCORE_W  running total of cleared rows
- game_over  out  1  sticky until reset

Behaviour:
- Reset (resetn=0 at posedge, any state): all columns 0, state IDLE, ready=1, touch_top=0, lock_done=0, lines_cleared=0, score=0, game_over=0. Reset mid-commit abandons the commit.
- IDLE:
  - ready=1.
  - lock_req=1 latches the piece inputs and moves to WRITE; ready drops the next cycle.
  - lock_req is ignored in every other state.
- WRITE (1 cycle):
  - Each mask bit set writes piece_colour into its cell, overwriting prior contents.
  - Cells with column>7 or row>=ROWS are dropped silently.
  - piece_colour=0 therefore writes empty; legal, effectively a no-op commit.
  - Sets row index r=0 and the clear counter to 0. Next state SCAN.
- SCAN (one row per cycle):
  - Row r is full if all 8 cells at row r are non-zero.
  - If full: rows r+1..ROWS-1 move down by one in every column, row ROWS-1 becomes 0, counter +1, r unchanged (re-test the same row next cycle).
  - If not full: r+1. When r=ROWS-1 is not full, go to CHECK.
  - The counter saturates at 3; a 2x2 piece can only complete 2 rows.
- CHECK (1 cycle): touch_top=1, board registers frozen. Next state WAIT.
- WAIT (1 cycle), touch_top=0:
  - The checker's registered outputs now reflect the frozen board; sample them.
  - end_game=1: go to OVER.
  - checked_game=1: pulse lock_done, load lines_cleared, score += counter (wraps modulo 2^SCORE_W), go to IDLE.
  - Neither set (protocol error): re-enter CHECK.
  - Both set: end_game wins.
  - Stale checked_game from the previous commit is never sampled, because the checker clears it in the CHECK cycle.
- OVER: game_over=1, ready=0, columns hold their final contents, no outputs change until reset.
- Latency with no clears: lock_req to lock_done = 1 + 1 + ROWS + 1 + 1 = 16 cycles. Each cleared row adds 1 cycle.

Decomposition:
- Shared package: ROWS, CELL_W, column count 8, state encoding (IDLE, WRITE, SCAN, CHECK, WAIT, OVER), mask bit positions.
- Sub-module board_row_shift: combinational. Inputs are one column and r; outputs the column with row r removed and zero shifted in at the top. Instantiated 8 times.

Test Plan:
1. Reset, then lock at x=0, y=0, mask=4'b1111, colour=3'b010 -> c1[5:0]=6'o22, c2[5:0]=6'o22; touch_top high in exactly one cycle; lock_done 16 cycles after lock_req; lines_cleared=0; score=0.
2. Pre-fill row 0 in columns 0..5 via three locks (x=0,2,4; mask=4'b0011; colour=1), then lock x=6, mask=4'b0011, colour=3 -> row 0 cleared; all columns' bits [2:0] = 0; lines_cleared=1; score=1; lock_done 17 cycles after that lock_req.
3. Fill rows 0 and 1 in columns 0..5 (mask=4'b1111 at x=0,2,4), then lock x=6, mask=4'b1111 -> lines_cleared=2; board all zero; score incremented by 2.
4. Lock x=3, y=11, mask=4'b1111, colour=5 -> c4[35:33]=5, row 12 cells dropped; checker model returns end_game=1 -> game_over=1, ready=0, lock_done never pulses; later lock_req ignored.
5. Lock x=7, mask=4'b1111 -> only c8 written; no write spills into c1. Lock_req pulsed during SCAN -> ignored; board unchanged by it.
6. Assert resetn=0 during SCAN -> next cycle all columns 0, ready=1, touch_top=0, score=0.
